// File: rtl/strobe_reg_pkg.sv
// Shared constants and FSM state encoding for the strobe register responder.
package strobe_reg_pkg;

    localparam int COEF_NUM = 16;
    localparam int COEF_W   = 16;
    localparam int ADDR_W   = 8;
    localparam int BIN_W    = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DO    = 3'd1,
        RD_REQ   = 3'd2,
        RD_WAIT  = 3'd3,
        ACK_HOLD = 3'd4
    } state_e;

endpackage

// File: rtl/strobe_reg_responder_if.sv
// Four-phase strobe/ack register bus: the initiator holds a strobe and its
// address/data stable until the matching ack rises, then drops the strobe;
// the responder drops ack in the cycle after it samples the strobe low.
interface strobe_reg_responder_if #(
    parameter int ADDR_W = strobe_reg_pkg::ADDR_W,
    parameter int COEF_W = strobe_reg_pkg::COEF_W,
    parameter int BIN_W  = strobe_reg_pkg::BIN_W
) ();

    logic              wr_strobe_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [COEF_W-1:0] wr_data_i;
    logic              wr_ack_o;
    logic              rd_strobe_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [BIN_W-1:0]  rd_data_o;
    logic              rd_ack_o;

    modport master (
        output wr_strobe_i, wr_addr_i, wr_data_i, rd_strobe_i, rd_addr_i,
        input  wr_ack_o, rd_ack_o, rd_data_o
    );

    modport slave (
        input  wr_strobe_i, wr_addr_i, wr_data_i, rd_strobe_i, rd_addr_i,
        output wr_ack_o, rd_ack_o, rd_data_o
    );

endinterface

// File: rtl/strobe_reg_responder_coef_bank.sv
// Coefficient storage. With SHADOW_COMMIT_EN defined, writes go to a shadow
// bank that is copied to the active bank on each rising edge of vs.
module coef_bank #(
    parameter int COEF_NUM = strobe_reg_pkg::COEF_NUM,
    parameter int COEF_W   = strobe_reg_pkg::COEF_W,
    parameter int ADDR_W   = strobe_reg_pkg::ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [COEF_W-1:0]          wr_data,
    input  logic                       vs,
    output logic [COEF_NUM*COEF_W-1:0] coef
);
    import strobe_reg_pkg::*;

    logic [COEF_W-1:0] active_q [COEF_NUM];

`ifdef SHADOW_COMMIT_EN
    logic [COEF_W-1:0] shadow_q [COEF_NUM];
    logic              vs_q;
    logic              commit;

    assign commit = vs & ~vs_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vs;
        end
    end

    // Addresses at or beyond COEF_NUM match no tap and are silently dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < COEF_NUM; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < COEF_NUM; i++) begin
                if (wr_en && wr_addr == ADDR_W'(i)) begin
                    shadow_q[i] <= wr_data;
                end
            end
        end
    end

    // Copy reads the shadow as it stood before any same-cycle write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < COEF_NUM; i++) begin
                active_q[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < COEF_NUM; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end
`else
    logic vs_unused;

    assign vs_unused = vs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < COEF_NUM; i++) begin
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < COEF_NUM; i++) begin
                if (wr_en && wr_addr == ADDR_W'(i)) begin
                    active_q[i] <= wr_data;
                end
            end
        end
    end
`endif

    for (genvar g = 0; g < COEF_NUM; g++) begin : g_pack
        assign coef[g*COEF_W +: COEF_W] = active_q[g];
    end

endmodule

// File: rtl/strobe_reg_responder.sv
// Four-phase strobe responder: coefficient writes and histogram bin reads.
// Optional SHADOW_COMMIT_EN makes writes take effect on the vs rising edge.
module strobe_reg_responder #(
    parameter int COEF_NUM = strobe_reg_pkg::COEF_NUM,
    parameter int COEF_W   = strobe_reg_pkg::COEF_W,
    parameter int ADDR_W   = strobe_reg_pkg::ADDR_W,
    parameter int BIN_W    = strobe_reg_pkg::BIN_W
) (
    input  logic                       clk,
    input  logic                       rst,
    strobe_reg_responder_if.slave      bus,
    output logic                       hist_rd_en_o,
    output logic [ADDR_W-1:0]          hist_rd_addr_o,
    input  logic [BIN_W-1:0]           hist_rd_data_i,
    input  logic                       vs_i,
    output logic [COEF_NUM*COEF_W-1:0] coef_o,
    output logic [2:0]                 dbg_state
);
    import strobe_reg_pkg::*;

    localparam logic [2:0] ST_IDLE     = IDLE;
    localparam logic [2:0] ST_WR_DO    = WR_DO;
    localparam logic [2:0] ST_RD_REQ   = RD_REQ;
    localparam logic [2:0] ST_RD_WAIT  = RD_WAIT;
    localparam logic [2:0] ST_ACK_HOLD = ACK_HOLD;

    logic [2:0]       state;
    logic             wr_ack;
    logic             rd_ack;
    logic [BIN_W-1:0] rd_data;
    logic             served_low;
    logic             coef_wr_en;

    // Whichever ack is up identifies the strobe being waited on in ACK_HOLD.
    assign served_low = wr_ack ? ~bus.wr_strobe_i : ~bus.rd_strobe_i;
    assign coef_wr_en = (state == ST_WR_DO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            wr_ack         <= 1'b0;
            rd_ack         <= 1'b0;
            rd_data        <= '0;
            hist_rd_en_o   <= 1'b0;
            hist_rd_addr_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.wr_strobe_i) begin
                        state <= ST_WR_DO;
                    end else if (bus.rd_strobe_i) begin
                        state          <= ST_RD_REQ;
                        hist_rd_en_o   <= 1'b1;
                        hist_rd_addr_o <= bus.rd_addr_i;
                    end
                end
                ST_WR_DO: begin
                    wr_ack <= 1'b1;
                    state  <= ST_ACK_HOLD;
                end
                ST_RD_REQ: begin
                    hist_rd_en_o <= 1'b0;
                    state        <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    rd_data <= hist_rd_data_i;
                    rd_ack  <= 1'b1;
                    state   <= ST_ACK_HOLD;
                end
                ST_ACK_HOLD: begin
                    if (served_low) begin
                        wr_ack <= 1'b0;
                        rd_ack <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    wr_ack       <= 1'b0;
                    rd_ack       <= 1'b0;
                    hist_rd_en_o <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_ack_o  = wr_ack;
    assign bus.rd_ack_o  = rd_ack;
    assign bus.rd_data_o = rd_data;
    assign dbg_state     = state;

    coef_bank #(
        .COEF_NUM (COEF_NUM),
        .COEF_W   (COEF_W),
        .ADDR_W   (ADDR_W)
    ) u_coef_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (coef_wr_en),
        .wr_addr (bus.wr_addr_i),
        .wr_data (bus.wr_data_i),
        .vs      (vs_i),
        .coef    (coef_o)
    );

endmodule

// File: tb/tb_strobe_reg_responder.sv
// Scoreboard bench for strobe_reg_responder; honours SHADOW_COMMIT_EN if defined.
module tb_strobe_reg_responder;
    import strobe_reg_pkg::*;

    localparam int CN = 16;
    localparam int CW = 16;
    localparam int AW = 8;
    localparam int BW = 16;
    localparam int CV = CN * CW;
    localparam int EW = CV + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hist_rd_en;
    logic [AW-1:0] hist_rd_addr;
    logic [BW-1:0] hist_rd_data = '0;
    logic          vs = 1'b0;
    logic [CV-1:0] coef;
    logic [2:0]    dbg_state;

    strobe_reg_responder_if #(.ADDR_W(AW), .COEF_W(CW), .BIN_W(BW)) bus ();

    strobe_reg_responder #(.COEF_NUM(CN), .COEF_W(CW), .ADDR_W(AW), .BIN_W(BW)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .hist_rd_en_o   (hist_rd_en),
        .hist_rd_addr_o (hist_rd_addr),
        .hist_rd_data_i (hist_rd_data),
        .vs_i           (vs),
        .coef_o         (coef),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- histogram RAM model (1-cycle latency) ----------------
    logic [BW-1:0] ram [256];
    always @(posedge clk) begin
        if (hist_rd_en) hist_rd_data <= ram[hist_rd_addr];
    end

    // ---------------- reference model ----------------
    logic [CW-1:0] m_active [CN];
    logic [CW-1:0] m_shadow [CN];

    function automatic logic [CV-1:0] pack_coef();
        logic [CV-1:0] r;
        for (int i = 0; i < CN; i++) r[i*CW +: CW] = m_active[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CN; i++) begin
            m_active[i] = '0;
            m_shadow[i] = '0;
        end
    endtask

    task automatic model_write(input logic [AW-1:0] addr, input logic [CW-1:0] data, input bit commit_same);
`ifdef SHADOW_COMMIT_EN
        if (commit_same) for (int i = 0; i < CN; i++) m_active[i] = m_shadow[i];
        if (int'(addr) < CN) m_shadow[addr] = data;
`else
        if (commit_same) begin end
        if (int'(addr) < CN) m_active[addr] = data;
`endif
    endtask

    task automatic model_commit();
`ifdef SHADOW_COMMIT_EN
        for (int i = 0; i < CN; i++) m_active[i] = m_shadow[i];
`endif
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int en_cnt = 0;
    logic [AW-1:0] en_addr = '0;
    logic wr_prev = 1'b0;
    logic rd_prev = 1'b0;

    task automatic check(input string name, input logic [CV-1:0] act, input logic [CV-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got event-missing expected event", name);
    endtask

    // Monitor: pops an expectation whenever an ack rises.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) begin
            if (hist_rd_en) begin
                en_cnt++;
                en_addr = hist_rd_addr;
            end
            if ((bus.wr_ack_o && !wr_prev) || (bus.rd_ack_o && !rd_prev)) begin
                check("ack_overlap", CV'(bus.wr_ack_o && bus.rd_ack_o), '0);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    e = exp_q.pop_front();
                    if (bus.wr_ack_o && !wr_prev) begin
                        check("ack_order_wr", CV'(e[CV]), CV'(0));
                        check("wr_coef", coef, e[CV-1:0]);
                    end else begin
                        check("ack_order_rd", CV'(e[CV]), CV'(1));
                        check("rd_data", CV'(bus.rd_data_o), CV'(e[BW-1:0]));
                    end
                end
            end
        end
        wr_prev = bus.wr_ack_o;
        rd_prev = bus.rd_ack_o;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ack(input bit is_wr, input int exp_lat, input bit vs_mid, input string name);
        int cyc = 0;
        bit seen = 0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (vs_mid && cyc == 1) vs = 1'b1;
            if (vs_mid && cyc == 2) vs = 1'b0;
            seen = is_wr ? bus.wr_ack_o : bus.rd_ack_o;
        end
        vs = 1'b0;
        if (!seen) fail_now({name, "_timeout"});
        else if (exp_lat >= 0) check(name, CV'(cyc), CV'(exp_lat));
    endtask

    task automatic release_strobe(input bit is_wr);
        if (is_wr) bus.wr_strobe_i = 1'b0;
        else bus.rd_strobe_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check(is_wr ? "wr_ack_fall" : "rd_ack_fall", CV'(is_wr ? bus.wr_ack_o : bus.rd_ack_o), '0);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [CW-1:0] data, input bit commit_same);
        @(negedge clk);
        bus.wr_addr_i = addr;
        bus.wr_data_i = data;
        bus.wr_strobe_i = 1'b1;
        model_write(addr, data, commit_same);
        exp_q.push_back({1'b0, pack_coef()});
        wait_ack(1'b1, 2, commit_same, "wr_latency");
        release_strobe(1'b1);
    endtask

    task automatic do_read(input logic [AW-1:0] addr);
        @(negedge clk);
        en_cnt = 0;
        bus.rd_addr_i = addr;
        bus.rd_strobe_i = 1'b1;
        exp_q.push_back({1'b1, CV'(ram[addr])});
        wait_ack(1'b0, 3, 1'b0, "rd_latency");
        check("hist_en_pulses", CV'(en_cnt), CV'(1));
        check("hist_addr", CV'(en_addr), CV'(addr));
        release_strobe(1'b0);
    endtask

    task automatic do_both(input logic [AW-1:0] waddr, input logic [CW-1:0] wdata, input logic [AW-1:0] raddr);
        @(negedge clk);
        en_cnt = 0;
        bus.wr_addr_i = waddr;
        bus.wr_data_i = wdata;
        bus.rd_addr_i = raddr;
        bus.wr_strobe_i = 1'b1;
        bus.rd_strobe_i = 1'b1;
        model_write(waddr, wdata, 1'b0);
        exp_q.push_back({1'b0, pack_coef()});
        exp_q.push_back({1'b1, CV'(ram[raddr])});
        wait_ack(1'b1, 2, 1'b0, "both_wr_latency");
        release_strobe(1'b1);
        wait_ack(1'b0, -1, 1'b0, "both_rd");
        check("both_hist_en_pulses", CV'(en_cnt), CV'(1));
        check("both_hist_addr", CV'(en_addr), CV'(raddr));
        release_strobe(1'b0);
    endtask

    task automatic vs_pulse();
        @(negedge clk);
        vs = 1'b1;
        model_commit();
        @(negedge clk);
        @(negedge clk);
        vs = 1'b0;
        @(negedge clk);
        check("coef_after_vs", coef, pack_coef());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ack"}, CV'(bus.wr_ack_o), '0);
        check({tag, "_rd_ack"}, CV'(bus.rd_ack_o), '0);
        check({tag, "_rd_data"}, CV'(bus.rd_data_o), '0);
        check({tag, "_hist_en"}, CV'(hist_rd_en), '0);
        check({tag, "_hist_addr"}, CV'(hist_rd_addr), '0);
        check({tag, "_coef"}, coef, '0);
        check({tag, "_state"}, CV'(dbg_state), CV'(IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.wr_strobe_i = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;
        bus.rd_strobe_i = 1'b0;
        bus.rd_addr_i = '0;
        for (int i = 0; i < 256; i++) ram[i] = BW'($urandom);
        ram[8'h80] = 16'h00AB;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Directed: write addr 3 data 0x1234, then commit.
        do_write(8'd3, 16'h1234, 1'b0);
        check("coef3_after_write", CV'(coef[63:48]), CV'(m_active[3]));
        vs_pulse();
        check("coef3_after_vs", CV'(coef[63:48]), CV'(16'h1234));

        // Directed: read bin 0x80.
        do_read(8'h80);
        check("rd_data_0x80", CV'(bus.rd_data_o), CV'(16'h00AB));

        // Directed: both strobes together, write served first.
        do_both(8'd5, 16'hBEEF, 8'h11);
        vs_pulse();

        // Directed: out-of-range write leaves all taps alone.
        do_write(8'd20, 16'hDEAD, 1'b0);
        vs_pulse();

        // Directed: write coinciding with commit edge.
        do_write(8'd7, 16'h7777, 1'b1);
        vs_pulse();

        // Randomized mix.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: do_write(AW'($urandom_range(0, 23)), CW'($urandom), $urandom_range(0, 3) == 0);
                1: do_read(AW'($urandom_range(0, 255)));
                2: do_both(AW'($urandom_range(0, 23)), CW'($urandom), AW'($urandom_range(0, 255)));
                default: vs_pulse();
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during RD_WAIT, strobe kept high across release.
        @(negedge clk);
        en_cnt = 0;
        bus.rd_addr_i = 8'h2C;
        bus.rd_strobe_i = 1'b1;
        exp_q.push_back({1'b1, CV'(ram[8'h2C])});
        repeat (2) @(negedge clk);
        check("state_rd_wait", CV'(dbg_state), CV'(RD_WAIT));
        rst = 1'b0;
        #1;
        void'(exp_q.pop_back());
        model_reset();
        check_reset_outputs("midreset");
        @(negedge clk);
        en_cnt = 0;
        rst = 1'b1;
        exp_q.push_back({1'b1, CV'(ram[8'h2C])});
        wait_ack(1'b0, 3, 1'b0, "post_reset_rd_latency");
        check("post_reset_hist_en_pulses", CV'(en_cnt), CV'(1));
        release_strobe(1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", CV'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/strobe_reg_responder.md
STROBE_REG_RESPONDER -- requirements
Module: strobe_reg_responder

Interface
REQ-001 Parameters (name, default, meaning): COEF_NUM, 16, FIR tap count; COEF_W, 16, coefficient width; ADDR_W, 8, strobe address width; BIN_W, 16, histogram bin width.
REQ-002 clk  in  1  pixel clock; the block's only clock.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 wr_strobe_i  in  1  write request, held high by the initiator until wr_ack_o is seen.
REQ-005 wr_addr_i  in  ADDR_W  coefficient index, stable while wr_strobe_i is high.
REQ-006 wr_data_i  in  COEF_W  coefficient value, stable while wr_strobe_i is high.
REQ-007 wr_ack_o  out  1  write acknowledge.
REQ-008 rd_strobe_i  in  1  read request, held high until rd_ack_o is seen.
REQ-009 rd_addr_i  in  ADDR_W  histogram bin index, stable while rd_strobe_i is high.
REQ-010 rd_data_o  out  BIN_W  bin value, valid while rd_ack_o is high.
REQ-011 rd_ack_o  out  1  read acknowledge.
REQ-012 hist_rd_en_o  out  1  one-cycle read enable to the histogram RAM.
REQ-013 hist_rd_addr_o  out  ADDR_W  histogram RAM address.
REQ-014 hist_rd_data_i  in  BIN_W  histogram RAM data, valid 1 cycle after hist_rd_en_o.
REQ-015 vs_i  in  1  vertical sync from the video path.
REQ-016 coef_o  out  COEF_NUM*COEF_W  active coefficients, tap 0 in the LSBs.

Function
REQ-017 The block SHALL be a four-phase responder. Each request is completed by ack rising. Ack stays high until the matching strobe falls. Ack SHALL then fall in the cycle after the strobe is sampled low.
REQ-018 The FSM SHALL have the states IDLE, WR_DO, RD_REQ, RD_WAIT, ACK_HOLD.
REQ-019 In IDLE, a sampled wr_strobe_i SHALL go to WR_DO. Otherwise a sampled rd_strobe_i SHALL go to RD_REQ.
REQ-020 If both strobes are high in the same cycle, the write SHALL be served first. The read SHALL be served after the write handshake completes.
REQ-021 WR_DO SHALL latch the write, raise wr_ack_o in the next cycle and go to ACK_HOLD. Write latency from strobe sampled to ack is 2 cycles.
REQ-022 A write with wr_addr_i >= COEF_NUM SHALL change no coefficient but SHALL still be acknowledged.
REQ-023 RD_REQ SHALL pulse hist_rd_en_o for one cycle with hist_rd_addr_o = rd_addr_i, then go to RD_WAIT.
REQ-024 RD_WAIT SHALL register hist_rd_data_i into rd_data_o, raise rd_ack_o and go to ACK_HOLD. Read latency from strobe sampled to ack is 3 cycles.
REQ-025 rd_data_o SHALL hold its value until the next read completes.
REQ-026 ACK_HOLD SHALL return to IDLE when the served strobe is low, dropping ack in the same transition.
REQ-027 New strobes SHALL be ignored outside IDLE.
REQ-028 vs_i SHALL be registered once. Its rising edge SHALL produce a one-cycle commit pulse.
REQ-029 hist_rd_en_o SHALL be low in every state except RD_REQ.

Reset
REQ-030 While rst is low, all of the following SHALL be 0: wr_ack_o, rd_ack_o, rd_data_o, hist_rd_en_o, hist_rd_addr_o, every coefficient, the shadow bank, and the registered vs_i. The FSM SHALL be in IDLE.
REQ-031 Reset asserted mid-handshake SHALL abort the transaction with no coefficient change.
REQ-032 After reset is released, a strobe still held high SHALL be served as a new request.

Configuration
REQ-033 With SHADOW_COMMIT_EN defined, writes SHALL land in a shadow bank. The whole shadow bank SHALL be copied to coef_o on the commit pulse.
REQ-034 With SHADOW_COMMIT_EN defined, if a write and a commit occur in the same cycle, the copy SHALL use the pre-write shadow. The new value SHALL appear at the next commit.
REQ-035 Without SHADOW_COMMIT_EN, writes SHALL update coef_o directly in the WR_DO cycle, and vs_i SHALL be unused.

Structure
REQ-036 Package strobe_reg_pkg SHALL hold the FSM state enum and the default width constants (ADDR_W, COEF_W, BIN_W, COEF_NUM).
REQ-037 Sub-module coef_bank SHALL hold the shadow and active registers, the write port and the commit logic, including the SHADOW_COMMIT_EN variant.

Verification
REQ-038 Write addr 3, data 0x1234 with macro off -> wr_ack_o high 2 cycles after strobe, and coef_o[63:48] = 0x1234.
REQ-039 Same write with macro on -> coef_o unchanged until the vs_i rising edge, then = 0x1234.
REQ-040 Read addr 0x80 with RAM returning 0x00AB -> one hist_rd_en_o pulse at addr 0x80, rd_ack_o 3 cycles after strobe, rd_data_o = 0x00AB.
REQ-041 Both strobes raised together -> wr_ack_o completes first, then a read with rd_ack_o follows, and no overlap of the acks.
REQ-042 Write to addr 20 -> wr_ack_o asserted, and all 16 coefficients unchanged.
REQ-043 rst low during RD_WAIT -> outputs 0 and FSM in IDLE. After release with rd_strobe_i still high -> a fresh read completes.
